// File: rtl/kogge_stone_adder_8_if.sv
// Operand/result bundle for the 8-bit Kogge-Stone adder.
// The master drives the operands and the slave returns the registered result.
interface kogge_stone_adder_8_if;
  logic [7:0] in1;
  logic [7:0] in2;
  logic       cin;
  logic [7:0] sum;
  logic       cout;

  modport master (output in1, output in2, output cin, input  sum, input  cout);
  modport slave  (input  in1, input  in2, input  cin, output sum, output cout);
endinterface

// File: rtl/kogge_stone_adder_8.sv
// 8-bit parallel-prefix adder with a 3-level Kogge-Stone carry network.
// The sum and carry-out are registered, so the result appears one cycle after the operands.
module kogge_stone_adder_8 (
  input  logic                   clk,
  input  logic                   rst_n,
  kogge_stone_adder_8_if.slave   bus
);
  localparam int unsigned W      = 8;
  localparam int unsigned LEVELS = 3;

  logic [W-1:0]              g;
  logic [W-1:0]              p;
  logic [LEVELS:0][W-1:0]    gl;
  logic [LEVELS:0][W-1:0]    pl;
  logic [W:0]                carry_c;
  logic [W-1:0]              sum_c;
  logic                      cout_c;

  assign g = bus.in1 & bus.in2;
  assign p = bus.in1 ^ bus.in2;

  // Prefix tree; cin enters as position -1 (G=cin, P=0) and is folded into node 0.
  always_comb begin
    gl = '0;
    pl = '0;
    gl[0]    = g;
    pl[0]    = p;
    gl[0][0] = g[0] | (p[0] & bus.cin);
    pl[0][0] = 1'b0;
    for (int k = 1; k <= int'(LEVELS); k++) begin
      for (int i = 0; i < int'(W); i++) begin
        if (i >= (1 << (k - 1))) begin
          gl[k][i] = gl[k-1][i] | (pl[k-1][i] & gl[k-1][i - (1 << (k - 1))]);
          pl[k][i] = pl[k-1][i] & pl[k-1][i - (1 << (k - 1))];
        end else begin
          gl[k][i] = gl[k-1][i];
          pl[k][i] = pl[k-1][i];
        end
      end
    end
  end

  assign carry_c = {gl[LEVELS], bus.cin};
  assign sum_c   = p ^ carry_c[W-1:0];
  assign cout_c  = carry_c[W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.sum  <= '0;
      bus.cout <= 1'b0;
    end else begin
      bus.sum  <= sum_c;
      bus.cout <= cout_c;
    end
  end
endmodule

// File: tb/tb_kogge_stone_adder_8.sv
// Directed and streaming checks for kogge_stone_adder_8, including asynchronous reset.
// Each result is sampled 1 time unit after the rising clock edge that captured it.
module tb_kogge_stone_adder_8;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  kogge_stone_adder_8_if bus ();

  kogge_stone_adder_8 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got {cout,sum}=%h expected %h", tag, obs, exp);
    end
  endtask

  // Drive operands away from the edge, then check the registered result after the edge.
  task automatic add_check(input string tag, input logic [7:0] a, input logic [7:0] b,
                           input logic c, input logic [8:0] exp);
    @(negedge clk);
    bus.in1 = a;
    bus.in2 = b;
    bus.cin = c;
    @(posedge clk);
    #1;
    check(tag, {bus.cout, bus.sum}, exp);
  endtask

  initial begin
    logic [7:0] a;
    logic [7:0] b;
    logic       c;
    total   = 0;
    bad     = 0;
    rst_n   = 1'b0;
    bus.in1 = 8'hFF;
    bus.in2 = 8'h01;
    bus.cin = 1'b1;
    #1;
    check("reset_immediate", {bus.cout, bus.sum}, 9'h000);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check("reset_held", {bus.cout, bus.sum}, 9'h000);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("reset_release", {bus.cout, bus.sum}, 9'h101);

    add_check("add_1_0_0",     8'd1,   8'd0,   1'b0, 9'd1);
    add_check("add_10_3_0",    8'd10,  8'd3,   1'b0, 9'd13);
    add_check("add_50_a0_1",   8'h50,  8'hA0,  1'b1, 9'h0F1);
    add_check("prop_ff_00_1",  8'hFF,  8'h00,  1'b1, 9'h100);
    add_check("prop_55_aa_1",  8'h55,  8'hAA,  1'b1, 9'h100);
    add_check("max_ff_ff_1",   8'hFF,  8'hFF,  1'b1, 9'h1FF);
    add_check("max_ff_ff_0",   8'hFF,  8'hFF,  1'b0, 9'h1FE);
    add_check("msb_80_80_0",   8'h80,  8'h80,  1'b0, 9'h100);
    add_check("gen_0f_01_0",   8'h0F,  8'h01,  1'b0, 9'h010);
    add_check("zero_00_00_0",  8'h00,  8'h00,  1'b0, 9'h000);
    add_check("cin_only",      8'h00,  8'h00,  1'b1, 9'h001);
    add_check("mid_7f_01_0",   8'h7F,  8'h01,  1'b0, 9'h080);

    // Back-to-back random stream with an asynchronous reset pulse in the middle.
    for (int n = 0; n < 1000; n++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      c = 1'($urandom);
      add_check("stream", a, b, c, 9'(a) + 9'(b) + 9'(c));
      if (n == 500) begin
        #2;
        rst_n = 1'b0;
        #1;
        check("midstream_reset", {bus.cout, bus.sum}, 9'h000);
        @(negedge clk);
        rst_n   = 1'b1;
        bus.in1 = 8'hC3;
        bus.in2 = 8'h5A;
        bus.cin = 1'b1;
        @(posedge clk);
        #1;
        check("after_reset", {bus.cout, bus.sum}, 9'h11E);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
